pll_lock_ctrl: RTL



---
 rtl/pll_ctrl_pkg.sv | 28 ++
 rtl/bit_sync.sv | 20 ++
 rtl/pll_lock_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the PLL lock controller.
package pll_ctrl_pkg;

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam int RETRY_W = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-stage flip-flop synchroniser for a single asynchronous bit.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync;

    always_ff @(posedge clk) begin
        if (!clr_n) sync <= '0;
        else        sync <= {sync[STAGES-2:0], d};
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset sequencer: pulses PLL reset, waits for and qualifies lock,
// releases the system reset, and restarts on timeout or lock loss.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 40000,
    parameter int LOCK_STABLE_CYC  = 4096,
    parameter int SYNC_STAGES      = 2,
    parameter int MAX_RETRIES      = 7
) (
    input  logic               clkin,
    input  logic               reset_n,
    input  logic               pll_lock_i,
    output logic               pll_reset_o,
    output logic               sys_reset_n_o,
    output logic               locked_o,
    output logic               lock_lost_o,
    output logic [RETRY_W-1:0] retry_cnt_o,
    output logic               fail_o
);

    localparam int CW = clog2(max3(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC));
    localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYC - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYC - 1);
    localparam logic [RETRY_W-1:0] FAIL_AT = RETRY_W'(MAX_RETRIES);

    state_e             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [RETRY_W-1:0] retry_n;
    logic               retry_inc;
    logic               lock_s;

    bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clkin),
        .clr_n (reset_n),
        .d     (pll_lock_i),
        .q     (lock_s)
    );

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CW'(1);
        retry_inc = 1'b0;
        case (state)
            RESET_PLL: begin
                if (cnt == RST_LAST) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end
            end
            WAIT_LOCK: begin
                // lock takes priority over a coincident timeout
                if (lock_s) begin
                    state_n = STABLE;
                    cnt_n   = '0;
                end else if (cnt == TO_LAST) begin
                    state_n   = RESET_PLL;
                    cnt_n     = '0;
                    retry_inc = 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == STB_LAST) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            end
            RUN: begin
                cnt_n = '0;
                if (!lock_s) begin
                    state_n   = RESET_PLL;
                    retry_inc = 1'b1;
                end
            end
            default: begin
                state_n = RESET_PLL;
                cnt_n   = '0;
            end
        endcase
    end

    assign retry_n = (retry_inc && retry_cnt_o != '1) ? retry_cnt_o + RETRY_W'(1) : retry_cnt_o;

    // Outputs follow the registered state one cycle later.
    always_ff @(posedge clkin) begin
        if (!reset_n) begin
            state         <= RESET_PLL;
            cnt           <= '0;
            pll_reset_o   <= 1'b1;
            sys_reset_n_o <= 1'b0;
            locked_o      <= 1'b0;
            lock_lost_o   <= 1'b0;
            retry_cnt_o   <= '0;
            fail_o        <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            retry_cnt_o   <= retry_n;
            fail_o        <= fail_o | (retry_n >= FAIL_AT);
            pll_reset_o   <= (state == RESET_PLL);
            sys_reset_n_o <= (state == RUN);
            locked_o      <= (state == RUN);
            lock_lost_o   <= locked_o && (state != RUN);
        end
    end

endmodule
